sdram_init_seq: RTL
===================

# sdram_init_seq

Power-up initialization sequencer for the SDRAM controller. After reset it drives the JEDEC start-up command sequence onto the SDRAM command bus: power-up wait, PRECHARGE ALL, two AUTO REFRESH, LOAD MODE REGISTER. It then raises `init_done` to hand the bus to the main command FSM. All inter-command delays come from one instance of the team's rollover counter, `flex_counter`; this block drives its `clear`, `count_enable` and `rollover_val` and consumes its `rollover_flag`.

## Interface
- `CNT_BITS`, 15: delay counter width; must hold `T_POWERUP-1`.
- `T_POWERUP`, 20000: cycles from the first post-reset cycle to PRECHARGE.
- `T_RP`, 3: cycles from PRECHARGE to the first REFRESH; must be ≥2.
- `T_RFC`, 8: cycles from REFRESH to the next command; must be ≥2.
- `T_MRD`, 2: cycles from LOAD MODE to `init_done`; must be ≥2.
- `MODE_REG`, 13'h0032: value placed on `addr` during LOAD MODE (CAS 3, burst 4).
- `clk` in 1: system clock, rising edge.
- `n_rst` in 1: asynchronous, active-low reset.
- `reinit` in 1: synchronous one-cycle request to restart the sequence.
- `cke` out 1: SDRAM clock enable.
- `cmd` out 4: {cs_n, ras_n, cas_n, we_n}.
- `addr` out 13: SDRAM address bus.
- `ba` out 2: bank address.
- `init_done` out 1: sequence complete; level signal.

## Operation
- Command encodings: NOP 4'b0111, PRECHARGE 4'b0010, AUTO_REFRESH 4'b0001, LOAD_MODE 4'b0000.
- FSM states: POWERUP, PRECHARGE, WAIT_RP, REFRESH1, WAIT_RFC1, REFRESH2, WAIT_RFC2, LOAD_MODE, WAIT_MRD, DONE.
- Outputs are Moore, decoded from the state register only.
- Command states last exactly one cycle and issue their command.
  - `addr` = 13'h0400 (A10 high) in PRECHARGE.
  - `addr` = `MODE_REG` and `ba` = 0 in LOAD_MODE.
  - `addr` = 0 and `ba` = 0 in every other state.
- Wait states and POWERUP issue NOP.
- Counter control:
  - Every command state asserts `clear`.
  - Every wait state asserts `count_enable`.
  - `rollover_val` = `T_POWERUP-1` in POWERUP, `T_RP-2` in WAIT_RP, `T_RFC-2` in WAIT_RFC1/2, `T_MRD-2` in WAIT_MRD.
  - A wait state exits on the cycle after `rollover_flag` is sampled high.
- POWERUP needs no clear cycle because the counter reset value is 0.
- DONE: `cmd` = NOP, `init_done` = 1, counter idle; the FSM holds here until `reinit`.
- `reinit` in any state:
  - next state is POWERUP and the counter is cleared that cycle;
  - `init_done` drops the cycle after `reinit` is sampled;
  - `reinit` has priority over a simultaneous `rollover_flag`;
  - `cke` stays 1.
- Reset at any time, including mid-sequence:
  - state = POWERUP; counter = 0, flag = 0;
  - `cke` = 0, `cmd` = 4'b1111 (INHIBIT), `addr` = 0, `ba` = 0, `init_done` = 0.
  - `cke` and `cmd` force during reset only; the first post-reset cycle already shows `cke` = 1 and NOP.

## Timing
- Cycle 0 is the first rising edge with `n_rst` high; the state is POWERUP.
- PRECHARGE occurs in cycle `T_POWERUP`.
- REFRESH1 occurs in cycle `T_POWERUP+T_RP`.
- REFRESH2 occurs in cycle `T_POWERUP+T_RP+T_RFC`.
- LOAD_MODE occurs in cycle `T_POWERUP+T_RP+2*T_RFC`.
- `init_done` rises in cycle `T_POWERUP+T_RP+2*T_RFC+T_MRD`.
- Command-to-command spacing is exactly the parameter value; there are no extra idle cycles.
- After `reinit` sampled in cycle r, the sequence restarts with POWERUP in cycle r+1, so PRECHARGE is at r+1+`T_POWERUP`.

## Structure
- Shared package `sdram_pkg` holds:
  - `sdram_cmd_t` enum (the four encodings plus INHIBIT);
  - `SDRAM_ADDR_W` = 13 and `SDRAM_BA_W` = 2;
  - `A10_PRECHARGE_ALL` = 13'h0400.
- The FSM state enum is local to the module.
- Exactly one sub-module: `flex_counter` with `NUM_CNT_BITS` = `CNT_BITS`. No other timers.

## Test plan
Run with `T_POWERUP`=10, `T_RP`=3, `T_RFC`=5, `T_MRD`=2.
- Reset held, then released -> `cke`=0 and `cmd`=4'b1111 during reset; `cmd`=NOP and `cke`=1 from cycle 0; `init_done`=0.
- Full sequence -> PRECHARGE with `addr`=13'h0400 in cycle 10; AUTO_REFRESH in 13 and 18; LOAD_MODE with `addr`=13'h0032, `ba`=0 in 23; `init_done`=1 from 25 and held for 100 cycles.
- `reinit` pulse in cycle 40 (DONE) -> `init_done`=0 in 41; PRECHARGE in 51; `init_done`=1 in 66.
- `reinit` in cycle 15 (WAIT_RFC1) -> no REFRESH in 18; PRECHARGE in 26.
- `reinit` in the cycle `rollover_flag` is high in WAIT_RP (cycle 12) -> no REFRESH in 13; POWERUP in 13; PRECHARGE in 23.
- `n_rst` asserted in cycle 20 for 3 cycles -> outputs return to reset values immediately; the full sequence restarts from the new cycle 0.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, bus widths and fixed address patterns.
package sdram_pkg;

  localparam int SDRAM_ADDR_W = 13;
  localparam int SDRAM_BA_W   = 2;

  // A10 high during PRECHARGE selects all banks.
  localparam logic [SDRAM_ADDR_W-1:0] A10_PRECHARGE_ALL = 13'h0400;

  // {cs_n, ras_n, cas_n, we_n}
  typedef enum logic [3:0] {
    CMD_LOAD_MODE    = 4'b0000,
    CMD_AUTO_REFRESH = 4'b0001,
    CMD_PRECHARGE    = 4'b0010,
    CMD_NOP          = 4'b0111,
    CMD_INHIBIT      = 4'b1111
  } sdram_cmd_t;

endpackage

// File: rtl/flex_counter.sv
// Rollover delay counter. Counts while enabled; the flag is high during the
// cycle in which the count equals rollover_val, so a consumer that advances on
// the flag spends exactly rollover_val+1 enabled cycles waiting.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count_r;
  logic [NUM_CNT_BITS-1:0] count_next_s;

  // Next count: clear wins, then wrap at rollover_val, otherwise increment while enabled.
  always_comb begin
    count_next_s = count_r;
    if (clear) begin
      count_next_s = {NUM_CNT_BITS{1'b0}};
    end else if (count_enable) begin
      if (count_r == rollover_val) begin
        count_next_s = {NUM_CNT_BITS{1'b0}};
      end else begin
        count_next_s = count_r + NUM_CNT_BITS'(1);
      end
    end else begin
      count_next_s = count_r;
    end
  end

  // Count register, zero out of reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_r <= {NUM_CNT_BITS{1'b0}};
    end else begin
      count_r <= count_next_s;
    end
  end

  // Flag is only meaningful while counting; an idle counter never signals rollover.
  always_comb begin
    rollover_flag = count_enable && (count_r == rollover_val);
  end

endmodule

// File: rtl/sdram_init_seq.sv
// SDRAM power-up initialization sequencer: power-up wait, PRECHARGE ALL,
// two AUTO REFRESH, LOAD MODE REGISTER, then init_done. All delays come
// from a single flex_counter driven per state.
module sdram_init_seq
  import sdram_pkg::*;
#(
  parameter int                      CNT_BITS  = 15,
  parameter int                      T_POWERUP = 20000,
  parameter int                      T_RP      = 3,
  parameter int                      T_RFC     = 8,
  parameter int                      T_MRD     = 2,
  parameter logic [SDRAM_ADDR_W-1:0] MODE_REG  = 13'h0032
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    reinit,
  output logic                    cke,
  output logic [3:0]              cmd,
  output logic [SDRAM_ADDR_W-1:0] addr,
  output logic [SDRAM_BA_W-1:0]   ba,
  output logic                    init_done
);

  typedef enum logic [3:0] {
    ST_POWERUP   = 4'd0,
    ST_PRECHARGE = 4'd1,
    ST_WAIT_RP   = 4'd2,
    ST_REFRESH1  = 4'd3,
    ST_WAIT_RFC1 = 4'd4,
    ST_REFRESH2  = 4'd5,
    ST_WAIT_RFC2 = 4'd6,
    ST_LOAD_MODE = 4'd7,
    ST_WAIT_MRD  = 4'd8,
    ST_DONE      = 4'd9
  } state_t;

  // Wait states are entered with the counter at zero (cleared by the preceding
  // command state), so a gap of T cycles between commands needs T-2 here.
  // POWERUP starts from the reset value and covers the whole T_POWERUP window.
  localparam logic [CNT_BITS-1:0] RV_POWERUP = CNT_BITS'(T_POWERUP - 1);
  localparam logic [CNT_BITS-1:0] RV_RP      = CNT_BITS'(T_RP - 2);
  localparam logic [CNT_BITS-1:0] RV_RFC     = CNT_BITS'(T_RFC - 2);
  localparam logic [CNT_BITS-1:0] RV_MRD     = CNT_BITS'(T_MRD - 2);

  state_t                  state_r;
  state_t                  next_state_s;
  logic                    clear_s;
  logic                    count_en_s;
  logic [CNT_BITS-1:0]     rollover_val_s;
  logic                    rollover_flag_s;
  sdram_cmd_t              cmd_s;
  logic [SDRAM_ADDR_W-1:0] addr_s;
  logic [SDRAM_BA_W-1:0]   ba_s;
  logic                    done_s;

  flex_counter #(
    .NUM_CNT_BITS (CNT_BITS)
  ) u_delay_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (clear_s),
    .count_enable  (count_en_s),
    .rollover_val  (rollover_val_s),
    .rollover_flag (rollover_flag_s)
  );

  // State register; reset always restarts the sequence at POWERUP.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= ST_POWERUP;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next state: reinit overrides everything, waits advance on rollover, commands last one cycle.
  always_comb begin
    next_state_s = state_r;
    if (reinit) begin
      next_state_s = ST_POWERUP;
    end else begin
      case (state_r)
        ST_POWERUP:   next_state_s = rollover_flag_s ? ST_PRECHARGE : ST_POWERUP;
        ST_PRECHARGE: next_state_s = ST_WAIT_RP;
        ST_WAIT_RP:   next_state_s = rollover_flag_s ? ST_REFRESH1 : ST_WAIT_RP;
        ST_REFRESH1:  next_state_s = ST_WAIT_RFC1;
        ST_WAIT_RFC1: next_state_s = rollover_flag_s ? ST_REFRESH2 : ST_WAIT_RFC1;
        ST_REFRESH2:  next_state_s = ST_WAIT_RFC2;
        ST_WAIT_RFC2: next_state_s = rollover_flag_s ? ST_LOAD_MODE : ST_WAIT_RFC2;
        ST_LOAD_MODE: next_state_s = ST_WAIT_MRD;
        ST_WAIT_MRD:  next_state_s = rollover_flag_s ? ST_DONE : ST_WAIT_MRD;
        ST_DONE:      next_state_s = ST_DONE;
        default:      next_state_s = ST_POWERUP;
      endcase
    end
  end

  // Moore decode of bus command, address and counter control from the state register.
  always_comb begin
    cmd_s          = CMD_NOP;
    addr_s         = {SDRAM_ADDR_W{1'b0}};
    ba_s           = {SDRAM_BA_W{1'b0}};
    done_s         = 1'b0;
    clear_s        = reinit;
    count_en_s     = 1'b0;
    rollover_val_s = {CNT_BITS{1'b0}};
    case (state_r)
      ST_POWERUP: begin
        count_en_s     = 1'b1;
        rollover_val_s = RV_POWERUP;
      end
      ST_PRECHARGE: begin
        cmd_s   = CMD_PRECHARGE;
        addr_s  = A10_PRECHARGE_ALL;
        clear_s = 1'b1;
      end
      ST_WAIT_RP: begin
        count_en_s     = 1'b1;
        rollover_val_s = RV_RP;
      end
      ST_REFRESH1, ST_REFRESH2: begin
        cmd_s   = CMD_AUTO_REFRESH;
        clear_s = 1'b1;
      end
      ST_WAIT_RFC1, ST_WAIT_RFC2: begin
        count_en_s     = 1'b1;
        rollover_val_s = RV_RFC;
      end
      ST_LOAD_MODE: begin
        cmd_s   = CMD_LOAD_MODE;
        addr_s  = MODE_REG;
        clear_s = 1'b1;
      end
      ST_WAIT_MRD: begin
        count_en_s     = 1'b1;
        rollover_val_s = RV_MRD;
      end
      ST_DONE: begin
        done_s = 1'b1;
      end
      default: begin
        cmd_s = CMD_NOP;
      end
    endcase
  end

  // Pins: while reset is held the bus is parked (CKE low, INHIBIT); released, it follows the decode.
  always_comb begin
    if (!n_rst) begin
      cke       = 1'b0;
      cmd       = CMD_INHIBIT;
      addr      = {SDRAM_ADDR_W{1'b0}};
      ba        = {SDRAM_BA_W{1'b0}};
      init_done = 1'b0;
    end else begin
      cke       = 1'b1;
      cmd       = cmd_s;
      addr      = addr_s;
      ba        = ba_s;
      init_done = done_s;
    end
  end

endmodule
